// File: rtl/dvsd_arb_pkg.sv
// Shared constants and types for the round-robin arbiter.
//   N_REQ  : number of requesters (fixed at 8)
//   IDX_W  : width of an encoded requester index
//   HCNT_W : width of the hold-time counter
//   arb_state_e : arbiter FSM states
package dvsd_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dvsd_rr_pick.sv
// Combinational cyclic priority encoder.
// Finds the lowest set bit of vec at or after position start, wrapping 7->0.
//   vec   in  [7:0] : candidate vector
//   start in  [2:0] : first index searched
//   idx   out [2:0] : winning index (meaningless when found=0)
//   found out       : at least one bit of vec is set
module dvsd_rr_pick
  import dvsd_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] dbl_sh;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate so that position 'start' lands on bit 0, pick the lowest set
  // bit with a fixed priority, then add 'start' back to un-rotate.
  always_comb begin
    dbl    = {vec, vec};
    dbl_sh = dbl >> start;
    rot    = dbl_sh[N_REQ-1:0];
    found  = |rot;
    off    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = start + off;
  end

endmodule

// File: rtl/dvsd_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded
// index and an optional hold-time limit that preempts an owner only when
// some other requester is waiting.
//   clk     in       : clock, rising edge
//   rst     in       : synchronous active-high reset
//   en      in       : enable; low blocks new grants and releases the owner
//   req     in  [7:0]: request lines
//   gnt     out [7:0]: registered one-hot grant
//   gnt_idx out [2:0]: registered index of gnt; holds last value when idle
//   gnt_vld out      : registered; a grant is active
//   eno     out      : combinational en & ~|req
//   gs      out      : same as gnt_vld
module dvsd_rr_arbiter
  import dvsd_arb_pkg::*;
#(
  parameter int N_REQ_P  = N_REQ,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             eno,
  output logic             gs
);

  // With the limit disabled the counter simply saturates at its full range.
  localparam logic [HCNT_W-1:0] HCNT_MAX =
    (MAX_HOLD == 0) ? {HCNT_W{1'b1}} : HCNT_W'(MAX_HOLD - 1);
  localparam bit LIMIT_ON = (MAX_HOLD != 0);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_vld_q, gnt_vld_d;

  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  others;
  logic [N_REQ-1:0]  pick_vec;
  logic [IDX_W-1:0]  pick_start;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              limit_hit;
  logic              release_c;

  assign owner_oh = N_REQ'(1) << gnt_idx_q;
  assign others   = req & ~owner_oh;

  // One shared picker: from ptr when idle, from the slot after the owner
  // (owner masked out) when handing over.
  assign pick_vec   = (state_q == GRANT) ? others : req;
  assign pick_start = (state_q == GRANT) ? gnt_idx_q + IDX_W'(1) : ptr_q;

  dvsd_rr_pick u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign limit_hit = LIMIT_ON && (hcnt_q == HCNT_MAX) && (|others);
  assign release_c = ~req[gnt_idx_q] | ~en | limit_hit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    unique case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d   = GRANT;
          gnt_d     = N_REQ'(1) << pick_idx;
          gnt_idx_d = pick_idx;
          gnt_vld_d = 1'b1;
          hcnt_d    = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d  = gnt_idx_q + IDX_W'(1);
          hcnt_d = '0;
          if (en && pick_found) begin
            // Back-to-back handover, no idle bubble.
            gnt_d     = N_REQ'(1) << pick_idx;
            gnt_idx_d = pick_idx;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
          end
        end else if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign gs      = gnt_vld_q;
  assign eno     = en & ~(|req);

endmodule

// File: doc/dvsd_rr_arbiter.md
# dvsd_rr_arbiter

Round-robin arbiter that shares one 8:3-encoded resource between eight requesters. It turns raw request lines into a registered, one-hot grant plus a 3-bit encoded index. Grant ownership is held until release, with an optional hold-time limit. Its encoded outputs and the `eno`/`gs` flags match the semantics of the team's priority-encoder blocks, so it drops into the same datapaths as a fair, stateful replacement.

## Interface
- `N_REQ`, 8: number of requesters; fixed at 8 in this version, with index width 3.
- `MAX_HOLD`, 16: maximum consecutive grant cycles while other requesters wait; range 1..255; 0 disables the limit.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: arbiter enable; low blocks new grants and forces release.
- `req` in 8: request lines; bit i = requester i.
- `gnt` out 8: registered one-hot grant.
- `gnt_idx` out 3: registered binary index of `gnt`; holds the last value when idle.
- `gnt_vld` out 1: registered; high when exactly one `gnt` bit is set.
- `eno` out 1: combinational; `en & ~|req` (enabled, nothing requested).
- `gs` out 1: equals `gnt_vld` (group select / grant active).

## Operation
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, state IDLE, pointer `ptr`=0, hold counter `hcnt`=0.
- Pick function: cyclic priority search of a request vector, starting at `ptr`. The lowest index at or after `ptr` wins, wrapping 7→0.
- State IDLE:
  - If `en` and `|req`, the winner is pick(`req`, `ptr`).
  - Next edge: the winner's `gnt` bit, `gnt_idx` and `gnt_vld` are set, `hcnt`=0, and the state goes to GRANT.
  - Otherwise the block stays in IDLE.
- State GRANT: the owner is `gnt_idx`. Each cycle `hcnt` increments, saturating at `MAX_HOLD`-1. A release is triggered by any of:
  - (a) `req[owner]`=0;
  - (b) `en`=0;
  - (c) `MAX_HOLD`≠0, `hcnt`==`MAX_HOLD`-1, and any other `req` bit set.
- On release:
  - `ptr` ← owner+1 mod 8.
  - If `en`, compute next = pick(`req` with the owner bit masked, owner+1).
  - If next exists, grant it on the same edge (back-to-back, no bubble), reset `hcnt`=0, and stay in GRANT.
  - Otherwise clear `gnt`/`gnt_vld` and go to IDLE.
- No competitor at the limit: the owner keeps the grant indefinitely and `hcnt` stays saturated.
- Simultaneous requests: only the pick winner is granted. The losers wait; the fairness bound is at most 7 grants ahead of any requester.
- `en` falling in GRANT: release on the next edge to IDLE with `gnt`=0; `ptr` still advances.
- `rst` mid-grant: all outputs and state return to reset values on that edge, regardless of `req`/`en`.
- `gnt` is never multi-hot. `gnt_idx` always encodes the set bit while `gnt_vld`=1.

## Timing
- Request to grant latency: 1 cycle. A `req` bit sampled high at edge k (IDLE, `en`=1) produces `gnt` after edge k.
- Release latency: 1 cycle. Owner `req` low at edge k removes or transfers `gnt` after edge k.
- Handover: back-to-back, zero idle cycles between owners when another request is pending.
- Timer preemption occurs after exactly `MAX_HOLD` grant cycles.
- `eno` is combinational from the inputs. All other outputs are registered, with no combinational path from `req` to `gnt`.

## Structure
- Package `dvsd_arb_pkg`:
  - `N_REQ`=8 and `IDX_W`=3 constants;
  - state enum {IDLE, GRANT};
  - `HCNT_W`=8.
- Sub-module `dvsd_rr_pick`: purely combinational cyclic priority encoder.
  - Inputs: `vec[7:0]`, `start[2:0]`.
  - Outputs: `idx[2:0]`, `found`.
  - Implementation: rotate, fixed priority, un-rotate.
  - Instantiated once in the arbiter, fed a muxed vector and start.
- Top module: FSM, `ptr`, `hcnt` and output registers.

## Test plan
- Reset: assert `rst` with `req`=8'hFF for 2 cycles → `gnt`=0, `gnt_vld`=0, `gnt_idx`=0. First grant after reset goes to index 0.
- Single requester: `req`=8'h08 from cycle 2, dropped at cycle 6 → `gnt`=8'h08 and `gnt_idx`=3 during cycles 3–6, `gnt`=0 from cycle 7, `eno`=1 once `req`=0.
- Fair rotation: `req`=8'hFF held, `MAX_HOLD`=4 → owners 0,1,2,…,7,0, each holding exactly 4 cycles with no bubbles.
- Back-to-back handover: `req`=8'h21 with 0 owning; drop `req[0]` → `gnt` moves 8'h01→8'h20 on the next edge with `gnt_vld` continuously 1.
- Limit not applied alone: `req`=8'h04 for 300 cycles, `MAX_HOLD`=16 → `gnt` stays 8'h04 throughout.
- `en` drop and mid-grant reset:
  - Owner 5, `en`=0 → `gnt`=0 the next cycle; re-enable with `req`=8'h21 → winner 0 (`ptr`=6 wraps).
  - Separately, `rst` during GRANT → all outputs 0 the next cycle.
